// File: rtl/nmea_frame_ctrl.sv
//------------------------------------------------------------------------------
// nmea_frame_ctrl : captures one NMEA sentence, verifies its XOR checksum and
//                   replays accepted sentences byte by byte to the parser.
// Revision        : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module nmea_frame_ctrl #(
  parameter int BUF_DEPTH   = 96,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  p_data,
  output logic        p_valid,
  output logic [15:0] ok_cnt,
  output logic [15:0] err_cnt,
  output logic        stale,
  output logic        busy,
  output logic [2:0]  state_o
);

  localparam int IDX_W = $clog2(BUF_DEPTH);
  localparam int LEN_W = $clog2(BUF_DEPTH + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [LEN_W-1:0] c_depth   = LEN_W'(BUF_DEPTH);
  localparam logic [TMR_W-1:0] c_timeout = TMR_W'(TIMEOUT_CYC);
  localparam logic [7:0]       c_dollar  = 8'h24;
  localparam logic [7:0]       c_star    = 8'h2A;
  localparam logic [7:0]       c_lf      = 8'h0A;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_CS_HI   = 3'd2,
    S_CS_LO   = 3'd3,
    S_CHECK   = 3'd4,
    S_REPLAY  = 3'd5,
    S_DROP    = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] rd_q, rd_d;
  logic [7:0]       xor_q, xor_d;
  logic [7:0]       cs_q, cs_d;
  logic             pend_q, pend_d;
  logic             p_valid_q, p_valid_d;
  logic [7:0]       p_data_q, p_data_d;
  logic [15:0]      ok_cnt_q, ok_cnt_d;
  logic [15:0]      err_cnt_q, err_cnt_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             stale_q, stale_d;
  logic             busy_q, busy_d;

  logic [7:0]       mem_q [BUF_DEPTH];

  logic             w_we;
  logic [IDX_W-1:0] w_waddr;
  logic [7:0]       w_wdata;
  logic             w_restart;
  logic             w_ok_inc;
  logic             w_err_inc;
  logic             w_match;
  logic             w_is_dollar;
  logic             w_hex_ok;
  logic [3:0]       w_hex_val;

  always_comb begin
    w_hex_ok  = 1'b0;
    w_hex_val = 4'h0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      w_hex_ok  = 1'b1;
      w_hex_val = rx_data[3:0];
    end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                 (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
      w_hex_ok  = 1'b1;
      w_hex_val = rx_data[3:0] + 4'd9;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    rd_d        = rd_q;
    xor_d       = xor_q;
    cs_d        = cs_q;
    pend_d      = pend_q;
    p_valid_d   = 1'b0;
    p_data_d    = p_data_q;
    w_we        = 1'b0;
    w_waddr     = IDX_W'(len_q);
    w_wdata     = rx_data;
    w_restart   = 1'b0;
    w_ok_inc    = 1'b0;
    w_err_inc   = 1'b0;
    w_match     = 1'b0;
    w_is_dollar = rx_valid && (rx_data == c_dollar);

    case (state_q)
      S_IDLE: begin
        if (w_is_dollar) w_restart = 1'b1;
      end
      S_CAPTURE: begin
        if (w_is_dollar) begin
          w_err_inc = 1'b1;
          w_restart = 1'b1;
        end else if (rx_valid && len_q == c_depth) begin
          w_err_inc = 1'b1;
          state_d   = S_DROP;
        end else if (rx_valid) begin
          w_we  = 1'b1;
          len_d = len_q + LEN_W'(1);
          if (rx_data == c_star) state_d = S_CS_HI;
          else                   xor_d   = xor_q ^ rx_data;
        end
      end
      S_CS_HI, S_CS_LO: begin
        if (rx_valid && w_hex_ok) begin
          if (state_q == S_CS_HI) begin
            cs_d    = {w_hex_val, 4'h0};
            state_d = S_CS_LO;
          end else begin
            cs_d    = {cs_q[7:4], w_hex_val};
            state_d = S_CHECK;
          end
        end else if (rx_valid) begin
          w_err_inc = 1'b1;
          if (w_is_dollar) w_restart = 1'b1;
          else             state_d   = S_DROP;
        end
      end
      S_CHECK: begin
        if (w_is_dollar) pend_d = 1'b1;
        if (xor_q == cs_q) begin
          w_ok_inc  = 1'b1;
          w_match   = 1'b1;
          state_d   = S_REPLAY;
          rd_d      = LEN_W'(1);
          p_valid_d = 1'b1;
          p_data_d  = mem_q[0];
        end else begin
          w_err_inc = 1'b1;
          pend_d    = 1'b0;
          state_d   = S_IDLE;
        end
      end
      S_REPLAY: begin
        if (rd_q < len_q) begin
          p_valid_d = 1'b1;
          p_data_d  = mem_q[IDX_W'(rd_q)];
          rd_d      = rd_q + LEN_W'(1);
          if (w_is_dollar) pend_d = 1'b1;
        end else begin
          // A '$' seen during check/replay (or on this last cycle) opens the next sentence.
          pend_d = 1'b0;
          if (pend_q || w_is_dollar) w_restart = 1'b1;
          else                       state_d   = S_IDLE;
        end
      end
      S_DROP: begin
        if (w_is_dollar)                         w_restart = 1'b1;
        else if (rx_valid && rx_data == c_lf)    state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (w_restart) begin
      w_we    = 1'b1;
      w_waddr = '0;
      w_wdata = c_dollar;
      len_d   = LEN_W'(1);
      xor_d   = 8'h00;
      state_d = S_CAPTURE;
    end

    ok_cnt_d  = (w_ok_inc  && ok_cnt_q  != 16'hFFFF) ? ok_cnt_q  + 16'd1 : ok_cnt_q;
    err_cnt_d = (w_err_inc && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;

    if (w_match)                    timer_d = '0;
    else if (timer_q == c_timeout)  timer_d = timer_q;
    else                            timer_d = timer_q + TMR_W'(1);
    stale_d = (timer_d == c_timeout);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      rd_q      <= '0;
      xor_q     <= 8'h00;
      cs_q      <= 8'h00;
      pend_q    <= 1'b0;
      p_valid_q <= 1'b0;
      p_data_q  <= 8'h00;
      ok_cnt_q  <= 16'h0000;
      err_cnt_q <= 16'h0000;
      timer_q   <= c_timeout;
      stale_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      rd_q      <= rd_d;
      xor_q     <= xor_d;
      cs_q      <= cs_d;
      pend_q    <= pend_d;
      p_valid_q <= p_valid_d;
      p_data_q  <= p_data_d;
      ok_cnt_q  <= ok_cnt_d;
      err_cnt_q <= err_cnt_d;
      timer_q   <= timer_d;
      stale_q   <= stale_d;
      busy_q    <= busy_d;
    end
  end

  // Sentence storage carries no reset; only indices below len are ever read.
  always_ff @(posedge clk) begin
    if (w_we) mem_q[w_waddr] <= w_wdata;
  end

  assign p_data  = p_data_q;
  assign p_valid = p_valid_q;
  assign ok_cnt  = ok_cnt_q;
  assign err_cnt = err_cnt_q;
  assign stale   = stale_q;
  assign busy    = busy_q;
  assign state_o = state_q;

endmodule

`default_nettype wire

// File: doc/nmea_frame_ctrl.md
NMEA_FRAME_CTRL -- requirements
Module: nmea_frame_ctrl

Interface
REQ-001 Parameter BUF_DEPTH, default 96, sentence buffer size in bytes; index width is clog2(BUF_DEPTH).
REQ-002 Parameter TIMEOUT_CYC, default 50_000_000, cycles without a good sentence before stale asserts.
REQ-003 clk  input  1  system clock; all logic on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-low.
REQ-005 rx_data  input  8  byte from the UART receiver.
REQ-006 rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-007 p_data  output  8  byte replayed to the NMEA parser.
REQ-008 p_valid  output  1  one-cycle strobe qualifying p_data.
REQ-009 ok_cnt  output  16  count of checksum-valid sentences, saturating.
REQ-010 err_cnt  output  16  count of rejected sentences, saturating.
REQ-011 stale  output  1  high when no good sentence has arrived within TIMEOUT_CYC.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 state_o  output  3  current FSM state encoding, for debug.

Function
REQ-014 FSM states SHALL be IDLE, CAPTURE, CS_HI, CS_LO, CHECK, REPLAY, DROP.
- IDLE: rx_valid with '$' stores '$' at buf[0], sets len=1, clears the running XOR, and moves to CAPTURE.
- Other bytes in IDLE are ignored.
REQ-015 CAPTURE: each rx_valid byte other than '*' or '$' SHALL be stored at buf[len], increment len, and be XORed into the running checksum.
REQ-016 CAPTURE: '*' SHALL be stored, increment len, and move to CS_HI without being XORed.
REQ-017 CAPTURE: '$' SHALL increment err_cnt and restart capture exactly as in IDLE (buf[0]='$', len=1, XOR cleared), staying in CAPTURE.
REQ-018 Overflow: a byte arriving in CAPTURE with len==BUF_DEPTH SHALL go to DROP and increment err_cnt.
REQ-019 CS_HI and CS_LO SHALL each accept one hex digit (0-9, A-F, a-f) per rx_valid and build an 8-bit received checksum, high nibble first.
- A non-hex byte SHALL go to DROP and increment err_cnt.
- If that non-hex byte is '$', capture SHALL restart (as in IDLE) instead of going to DROP.
REQ-020 CHECK SHALL last exactly one cycle.
- Match of running XOR and received checksum: increment ok_cnt, go to REPLAY.
- Mismatch: increment err_cnt, go to IDLE.
REQ-021 REPLAY SHALL drive p_valid=1 with p_data=buf[i] on consecutive cycles, i=0..len-1, then return to IDLE.
- Latency: first replayed byte one cycle after CHECK.
- Exactly len strobes, with no gaps.
REQ-022 During CHECK and REPLAY, rx bytes SHALL NOT be stored.
- A '$' received then SHALL set a pending flag.
- When the pending flag is set, REPLAY exits to CAPTURE with buf[0]='$', len=1, XOR cleared, instead of to IDLE.
- Other bytes received then are discarded without counting.
REQ-023 DROP SHALL discard bytes until '$', which restarts capture as in IDLE; '\n' SHALL return to IDLE.
REQ-024 p_valid SHALL be 0 in every state except REPLAY, and p_data SHALL hold its last value when p_valid is 0.
REQ-025 Stale timer SHALL clear to 0 in the CHECK cycle with a match and otherwise increment each cycle, saturating at TIMEOUT_CYC.
- stale = (timer == TIMEOUT_CYC), registered.
REQ-026 ok_cnt and err_cnt SHALL saturate at 0xFFFF, not wrap.
REQ-027 Checksum arithmetic SHALL be an 8-bit XOR.
- Hex conversion: '0'-'9' -> 0-9, 'A'-'F' and 'a'-'f' -> 10-15.

Reset
REQ-028 With rst=0 at a clock edge, the following SHALL hold the next cycle regardless of current state, including mid-REPLAY: state=IDLE, len=0, XOR=0, pending=0, p_valid=0, p_data=0, ok_cnt=0, err_cnt=0, stale=1, timer=TIMEOUT_CYC, busy=0.
REQ-029 Buffer contents SHALL NOT need a reset value; reads SHALL only occur below len.

Verification
REQ-030 Feed "$GPRMC,1,A,0437.12,N,07405.55,W*" plus the correct 2-digit checksum -> ok_cnt=1, err_cnt=0, exactly len consecutive p_valid strobes reproducing the bytes '$' through '*', stale deasserts.
REQ-031 Same sentence with a corrupted checksum digit -> err_cnt=1, no p_valid pulses, FSM back in IDLE.
REQ-032 Feed BUF_DEPTH+1 bytes after '$' with no '*' -> err_cnt=1, DROP; a following valid sentence -> ok_cnt=1.
REQ-033 Feed "$GP" then '$' then a valid sentence -> err_cnt=1, ok_cnt=1, replay contains only the second sentence.
REQ-034 Assert rst=0 on the 5th REPLAY cycle -> p_valid=0 the next cycle and all outputs at their REQ-028 values; with TIMEOUT_CYC=100 and no input, stale stays high.
REQ-035 ok_cnt preloaded to 0xFFFF via a long run or force, then one good sentence -> ok_cnt stays 0xFFFF.
